alu_writeback_queue: RTL and testbench

//  Consumer end of the ALU result interface: accepts result/zero/negative from the
//  ALU operand/control stage, updates the architectural N/Z flag register and queues

---
 rtl/alu_writeback_queue.sv | 131 +++++++++++++
 tb/tb_alu_writeback_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_queue.sv
// alu_writeback_queue
// Consumer end of the ALU result interface. It keeps the architectural N/Z flags
// and holds register-file writes in a small in-order FIFO until the regfile write
// port drains them. It also answers a pending-destination query for hazard checks.
module alu_writeback_queue #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_result,
    input  logic                    in_zero,
    input  logic                    in_negative,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic                    in_write_rd,
    input  logic                    in_set_flags,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [REG_ADDR_W-1:0]   wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    flag_z,
    output logic                    flag_n,
    input  logic [REG_ADDR_W-1:0]   query_addr,
    output logic                    query_hit,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0]     mem_data [DEPTH];
    logic [DEPTH-1:0]      ent_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic push;
    logic pop;
    logic flag_upd;

    // in_ready depends only on the registered count, so wb_ready never reaches it
    // combinationally; a pop while full frees the slot for the following cycle.
    assign in_ready = (count != FULL_CNT);
    assign wb_valid = (count != '0);
    assign push     = in_valid & in_write_rd & in_ready;
    assign pop      = wb_valid & wb_ready;

    // A rejected register-writing entry must not touch the flags; the source retries.
    assign flag_upd = in_valid & in_set_flags & (in_write_rd ? in_ready : 1'b1);

    // Head of the FIFO is presented straight from storage; no bypass of the push.
    assign wb_addr = mem_addr[rd_ptr];
    assign wb_data = mem_data[rd_ptr];

    // Pointer and occupancy tracking; flush overrides any push or pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on push.
    // NOTE: the storage is reset because wb_addr/wb_data read it directly and must be
    // zero out of reset; at this depth the reset cost is negligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_addr[wr_ptr] <= in_rd;
            mem_data[wr_ptr] <= in_result;
        end
    end

    // Per-entry occupancy flags used by the pending-destination query.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            if (pop)  ent_valid[rd_ptr] <= 1'b0;
            if (push) ent_valid[wr_ptr] <= 1'b1;
        end
    end

    // Architectural flags; still updated on a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (flag_upd) begin
            flag_z <= in_zero;
            flag_n <= in_negative;
        end
    end

    // Any stored entry (including a head being popped) targeting query_addr.
    // NOTE: the output gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (mem_addr[i] == query_addr)) query_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_writeback_queue.sv
// Self-checking bench for alu_writeback_queue: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_alu_writeback_queue;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int DEPTH      = 2;

    typedef struct {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_result;
    logic                   in_zero;
    logic                   in_negative;
    logic [REG_ADDR_W-1:0]  in_rd;
    logic                   in_write_rd;
    logic                   in_set_flags;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [REG_ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]      wb_data;
    logic                   flag_z;
    logic                   flag_n;
    logic [REG_ADDR_W-1:0]  query_addr;
    logic                   query_hit;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    wb_entry_t exp_q[$];
    logic      exp_z = 1'b0;
    logic      exp_n = 1'b0;

    alu_writeback_queue #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_negative(in_negative), .in_rd(in_rd),
        .in_write_rd(in_write_rd), .in_set_flags(in_set_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n),
        .query_addr(query_addr), .query_hit(query_hit), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard/monitor: at each falling edge compare DUT outputs with the model,
    // then advance the model by what the coming rising edge will do.
    initial begin
        bit ready_m;
        bit hit_m;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_z = 1'b0;
                exp_n = 1'b0;
            end else begin
                ready_m = (exp_q.size() != DEPTH);
                hit_m = 1'b0;
                foreach (exp_q[i]) if (exp_q[i].addr == query_addr) hit_m = 1'b1;
                check("count",     32'(count),     32'(exp_q.size()));
                check("in_ready",  32'(in_ready),  32'(ready_m));
                check("wb_valid",  32'(wb_valid),  32'(exp_q.size() != 0));
                check("flag_z",    32'(flag_z),    32'(exp_z));
                check("flag_n",    32'(flag_n),    32'(exp_n));
                check("query_hit", 32'(query_hit), 32'(hit_m));
                if (exp_q.size() != 0) begin
                    check("wb_addr", 32'(wb_addr), 32'(exp_q[0].addr));
                    check("wb_data", wb_data,      exp_q[0].data);
                end
                if (in_valid && in_set_flags && (in_write_rd ? ready_m : 1'b1)) begin
                    exp_z = in_zero;
                    exp_n = in_negative;
                end
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (wb_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                    if (in_valid && in_write_rd && ready_m) begin
                        wb_entry_t e;
                        e.addr = in_rd;
                        e.data = in_result;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // Apply one cycle of stimulus, then advance past the next rising edge.
    task automatic drive(input logic v, input logic wr, input logic sf, input logic z,
                         input logic n, input logic [REG_ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] d, input logic wbr,
                         input logic [REG_ADDR_W-1:0] qa, input logic fl);
        in_valid = v; in_write_rd = wr; in_set_flags = sf; in_zero = z; in_negative = n;
        in_rd = rd; in_result = d; wb_ready = wbr; query_addr = qa; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wbr, input logic [REG_ADDR_W-1:0] qa);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, wbr, qa, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},    32'(count),    32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_addr"},  32'(wb_addr),  32'd0);
        check({tag, "_wb_data"},  wb_data,       32'd0);
        check({tag, "_flag_z"},   32'(flag_z),   32'd0);
        check({tag, "_flag_n"},   32'(flag_n),   32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_write_rd = 0; in_set_flags = 0; in_zero = 0; in_negative = 0;
        in_rd = '0; in_result = '0; wb_ready = 0; query_addr = '0; flush = 0;
        #1;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single push with flags, drained immediately.
        drive(1, 1, 1, 0, 0, 4'd3, 32'h0000_0005, 1, 4'd3, 0);
        idle(1, 4'd3);
        idle(1, 4'd0);

        // Fill the queue, hold a third push, compare still updates flags.
        drive(1, 1, 0, 0, 0, 4'd1, 32'h1111_0001, 0, 4'd0, 0);
        drive(1, 1, 0, 0, 0, 4'd2, 32'h2222_0002, 0, 4'd2, 0);
        drive(1, 1, 0, 0, 0, 4'd4, 32'h4444_0004, 0, 4'd4, 0);
        drive(1, 0, 1, 1, 0, 4'd9, 32'h0, 0, 4'd1, 0);
        check("held_flag_z", 32'(flag_z), 32'd1);
        check("held_count",  32'(count),  32'd2);
        // Release with rd=4 held: pops rd=1 first, rd=4 enters next cycle.
        drive(1, 1, 0, 0, 0, 4'd4, 32'h4444_0004, 1, 4'd4, 0);
        drive(1, 1, 0, 0, 0, 4'd4, 32'h4444_0004, 1, 4'd4, 0);
        repeat (3) idle(1, 4'd4);

        // Query and flush.
        drive(1, 1, 0, 0, 0, 4'd7, 32'h7777_0007, 0, 4'd7, 0);
        idle(0, 4'd7);
        check("query_hit_7", 32'(query_hit), 32'd1);
        idle(0, 4'd6);
        check("query_hit_6", 32'(query_hit), 32'd0);
        drive(0, 0, 0, 0, 0, 4'd0, 32'h0, 0, 4'd7, 1);
        check("flush_wb_valid",  32'(wb_valid),  32'd0);
        check("flush_query_hit", 32'(query_hit), 32'd0);
        check("flush_flag_z",    32'(flag_z),    32'd1);

        // Flush with a flag-setting write: flags update, write discarded.
        drive(1, 1, 1, 0, 1, 4'd5, 32'h5555_0005, 0, 4'd5, 1);
        idle(1, 4'd5);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  REG_ADDR_W'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), REG_ADDR_W'($urandom_range(0, 7)),
                  1'($urandom_range(0, 29) == 0));
        end

        // Reset mid-run with two entries queued and flags set.
        idle(1, 4'd0);
        idle(1, 4'd0);
        drive(1, 1, 1, 1, 1, 4'd8, 32'h8888_0008, 0, 4'd0, 0);
        drive(1, 1, 1, 1, 1, 4'd9, 32'h9999_0009, 0, 4'd0, 0);
        check("pre_reset_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1, 4'd0);
        idle(1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
